// File: rtl/dcache_pkg.sv
// Shared types and lane helpers for the uncached data-memory port.
// Helpers work on a 64-bit word; 32-bit instances zero-extend into them and truncate the result.
package dcache_pkg;

   localparam int unsigned MAX_DATA_W = 64;
   localparam int unsigned BYTES      = MAX_DATA_W / 8;
   localparam int unsigned OFF_W      = $clog2(BYTES);

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } ldst_size_e;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_REQ,
      LD_WAIT,
      LD_DROP
   } ld_state_e;

   function automatic logic [BYTES-1:0] byte_en(input ldst_size_e size, input logic [OFF_W-1:0] off);
      logic [BYTES-1:0] m;
      case (size)
         SZ_BYTE: m = 8'h01;
         SZ_HALF: m = 8'h03;
         SZ_WORD: m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

   function automatic logic is_misaligned(input ldst_size_e size, input logic [OFF_W-1:0] off);
      logic r;
      case (size)
         SZ_HALF:  r = off[0];
         SZ_WORD:  r = |off[1:0];
         SZ_DWORD: r = |off[2:0];
         default:  r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [MAX_DATA_W-1:0] align_ext(input logic [MAX_DATA_W-1:0] word,
                                                       input logic [OFF_W-1:0] off,
                                                       input ldst_size_e size,
                                                       input logic sgn);
      logic [MAX_DATA_W-1:0] s;
      logic [MAX_DATA_W-1:0] r;
      s = word >> {off, 3'b000};
      case (size)
         SZ_BYTE: r = {{56{sgn & s[7]}},  s[7:0]};
         SZ_HALF: r = {{48{sgn & s[15]}}, s[15:0]};
         SZ_WORD: r = {{32{sgn & s[31]}}, s[31:0]};
         default: r = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dcache_st_buf.sv
// Store-buffer FIFO of word-aligned, lane-shifted stores with a word-address match
// across all valid entries; the youngest matching entry wins.
module dcache_st_buf
   import dcache_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned STB_DEPTH = 4,
   localparam int unsigned NB       = DATA_W / 8,
   localparam int unsigned WA_W     = ADDR_W - $clog2(NB)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_i,
   input  logic [WA_W-1:0]   push_waddr_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic [NB-1:0]     push_be_i,
   input  logic              pop_i,
   input  logic [WA_W-1:0]   lookup_waddr_i,
   output logic              full_o,
   output logic              empty_o,
   output logic              hit_any_o,
   output logic [DATA_W-1:0] hit_data_o,
   output logic [NB-1:0]     hit_be_o,
   output logic [WA_W-1:0]   head_waddr_o,
   output logic [DATA_W-1:0] head_data_o,
   output logic [NB-1:0]     head_be_o
);

   localparam int unsigned PTR_W = $clog2(STB_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WA_W-1:0]   waddr_q [STB_DEPTH];
   logic [DATA_W-1:0] data_q  [STB_DEPTH];
   logic [NB-1:0]     be_q    [STB_DEPTH];
   logic [PTR_W-1:0]  rd_q, wr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [PTR_W-1:0]  idx;

   assign full_o       = (cnt_q == CNT_W'(STB_DEPTH));
   assign empty_o      = (cnt_q == '0);
   assign head_waddr_o = waddr_q[rd_q];
   assign head_data_o  = data_q[rd_q];
   assign head_be_o    = be_q[rd_q];

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      hit_any_o  = 1'b0;
      hit_data_o = '0;
      hit_be_o   = '0;
      idx        = '0;
      for (int unsigned i = 0; i < STB_DEPTH; i++) begin
         idx = rd_q + PTR_W'(i);
         if ((CNT_W'(i) < cnt_q) && (waddr_q[idx] == lookup_waddr_i)) begin
            hit_any_o  = 1'b1;
            hit_data_o = data_q[idx];
            hit_be_o   = be_q[idx];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < STB_DEPTH; i++) begin
            waddr_q[i] <= '0;
            data_q[i]  <= '0;
            be_q[i]    <= '0;
         end
      end else begin
         if (push_i) begin
            waddr_q[wr_q] <= push_waddr_i;
            data_q[wr_q]  <= push_data_i;
            be_q[wr_q]    <= push_be_i;
            wr_q          <= wr_q + 1'b1;
         end
         if (pop_i) begin
            rd_q <= rd_q + 1'b1;
         end
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/dcache_uncached_port.sv
// Uncached LSU data port: single outstanding aligned load plus a store buffer drained to memory.
// Define STORE_FWD_EN to let a load fully covered by the youngest matching buffered store be forwarded.
module dcache_uncached_port
   import dcache_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned STB_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                recoverFlag_i,
   input  logic                ldEn_i,
   input  logic [ADDR_W-1:0]   ldAddr_i,
   input  logic [1:0]          ldSize_i,
   input  logic                ldSigned_i,
   output logic                ldReady_o,
   output logic                ldDataValid_o,
   output logic [DATA_W-1:0]   ldData_o,
   output logic                ldMisalign_o,
   input  logic                stEn_i,
   input  logic [ADDR_W-1:0]   stAddr_i,
   input  logic [DATA_W-1:0]   stData_i,
   input  logic [1:0]          stSize_i,
   output logic                stReady_o,
   output logic                stMisalign_o,
   output logic                stBufEmpty_o,
   output logic [ADDR_W-1:0]   memLdAddr_o,
   output logic                memLdValid_o,
   input  logic                memLdReady_i,
   input  logic [DATA_W-1:0]   memLdData_i,
   input  logic                memLdDataValid_i,
   output logic [ADDR_W-1:0]   memStAddr_o,
   output logic [DATA_W-1:0]   memStData_o,
   output logic [DATA_W/8-1:0] memStByteEn_o,
   output logic                memStValid_o,
   input  logic                memStReady_i
);

   localparam int unsigned NB   = DATA_W / 8;
   localparam int unsigned NOFF = $clog2(NB);
   localparam int unsigned WA_W = ADDR_W - NOFF;
   localparam bit HAS_DWORD     = (DATA_W == 64);
`ifdef STORE_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   ld_state_e         state_q;
   logic [OFF_W-1:0]  ld_off_q;
   ldst_size_e        ld_size_q;
   logic              ld_sgn_q;
   logic [ADDR_W-1:0] memLdAddr_q;
   logic              memLdValid_q, ldDataValid_q, ldMisalign_q, stMisalign_q;
   logic [DATA_W-1:0] ldData_q;

   ldst_size_e        ld_size, st_size;
   logic [OFF_W-1:0]  ld_off, st_off;
   logic              ld_mis, st_mis, ld_acc, st_acc, push, pop, fwd_ok;
   logic [NB-1:0]     ld_need_be, st_be;
   logic [DATA_W-1:0] st_masked, st_lane;
   logic              full, empty, hit_any;
   logic [DATA_W-1:0] hit_data, head_data;
   logic [NB-1:0]     hit_be, head_be;
   logic [WA_W-1:0]   head_waddr;

   assign ld_size    = ldst_size_e'(ldSize_i);
   assign st_size    = ldst_size_e'(stSize_i);
   assign ld_off     = OFF_W'(ldAddr_i[NOFF-1:0]);
   assign st_off     = OFF_W'(stAddr_i[NOFF-1:0]);
   assign ld_mis     = is_misaligned(ld_size, ld_off) || (!HAS_DWORD && ld_size == SZ_DWORD);
   assign st_mis     = is_misaligned(st_size, st_off) || (!HAS_DWORD && st_size == SZ_DWORD);
   assign ld_need_be = NB'(byte_en(ld_size, ld_off));
   assign st_be      = NB'(byte_en(st_size, st_off));

   assign fwd_ok    = FWD_EN && hit_any && !ld_mis && ((hit_be & ld_need_be) == ld_need_be);
   assign ldReady_o = reset && (state_q == LD_IDLE) && (!hit_any || fwd_ok);
   assign ld_acc    = ldEn_i && ldReady_o;

   assign stReady_o    = reset && !full;
   assign st_acc       = stEn_i && stReady_o;
   assign push         = st_acc && !st_mis;
   assign pop          = memStValid_o && memStReady_i;
   assign stBufEmpty_o = empty;
   assign memStValid_o = !empty;
   assign memStAddr_o  = {head_waddr, {NOFF{1'b0}}};
   assign memStData_o  = head_data;
   assign memStByteEn_o = head_be;

   assign memLdAddr_o   = memLdAddr_q;
   assign memLdValid_o  = memLdValid_q;
   assign ldDataValid_o = ldDataValid_q;
   assign ldData_o      = ldData_q;
   assign ldMisalign_o  = ldMisalign_q;
   assign stMisalign_o  = stMisalign_q;

   always_comb begin
      st_masked = stData_i;
      case (st_size)
         SZ_BYTE: st_masked = DATA_W'(stData_i[7:0]);
         SZ_HALF: st_masked = DATA_W'(stData_i[15:0]);
         SZ_WORD: st_masked = DATA_W'(stData_i[31:0]);
         default: ;
      endcase
      st_lane = st_masked << {st_off, 3'b000};
   end

   dcache_st_buf #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .STB_DEPTH(STB_DEPTH)
   ) u_st_buf (
      .clk           (clk),
      .reset         (reset),
      .push_i        (push),
      .push_waddr_i  (stAddr_i[ADDR_W-1:NOFF]),
      .push_data_i   (st_lane),
      .push_be_i     (st_be),
      .pop_i         (pop),
      .lookup_waddr_i(ldAddr_i[ADDR_W-1:NOFF]),
      .full_o        (full),
      .empty_o       (empty),
      .hit_any_o     (hit_any),
      .hit_data_o    (hit_data),
      .hit_be_o      (hit_be),
      .head_waddr_o  (head_waddr),
      .head_data_o   (head_data),
      .head_be_o     (head_be)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= LD_IDLE;
         ld_off_q      <= '0;
         ld_size_q     <= SZ_BYTE;
         ld_sgn_q      <= 1'b0;
         memLdAddr_q   <= '0;
         memLdValid_q  <= 1'b0;
         ldDataValid_q <= 1'b0;
         ldMisalign_q  <= 1'b0;
         ldData_q      <= '0;
      end else begin
         ldDataValid_q <= 1'b0;
         ldMisalign_q  <= 1'b0;
         case (state_q)
            LD_IDLE: begin
               if (ld_acc) begin
                  if (ld_mis) begin
                     ldMisalign_q <= 1'b1;
                     ldData_q     <= '0;
                  end else if (fwd_ok) begin
                     ldData_q      <= DATA_W'(align_ext(MAX_DATA_W'(hit_data), ld_off, ld_size, ldSigned_i));
                     ldDataValid_q <= 1'b1;
                  end else begin
                     ld_off_q     <= ld_off;
                     ld_size_q    <= ld_size;
                     ld_sgn_q     <= ldSigned_i;
                     memLdAddr_q  <= {ldAddr_i[ADDR_W-1:NOFF], {NOFF{1'b0}}};
                     memLdValid_q <= 1'b1;
                     state_q      <= LD_REQ;
                  end
               end
            end
            LD_REQ: begin
               // A flush that coincides with the handshake still owes us a response to swallow.
               if (recoverFlag_i) begin
                  memLdValid_q <= 1'b0;
                  state_q      <= memLdReady_i ? LD_DROP : LD_IDLE;
               end else if (memLdReady_i) begin
                  memLdValid_q <= 1'b0;
                  state_q      <= LD_WAIT;
               end
            end
            LD_WAIT: begin
               if (recoverFlag_i) begin
                  state_q <= memLdDataValid_i ? LD_IDLE : LD_DROP;
               end else if (memLdDataValid_i) begin
                  ldData_q      <= DATA_W'(align_ext(MAX_DATA_W'(memLdData_i), ld_off_q, ld_size_q, ld_sgn_q));
                  ldDataValid_q <= 1'b1;
                  state_q       <= LD_IDLE;
               end
            end
            LD_DROP: begin
               if (memLdDataValid_i) begin
                  state_q <= LD_IDLE;
               end
            end
            default: state_q <= LD_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stMisalign_q <= 1'b0;
      end else begin
         stMisalign_q <= st_acc && st_mis;
      end
   end

endmodule

// File: tb/tb_dcache_uncached_port.sv
// Directed bench for dcache_uncached_port with a queue-based store/load reference model.
module tb_dcache_uncached_port;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          recoverFlag_i = 1'b0;
   logic          ldEn_i = 1'b0;
   logic [AW-1:0] ldAddr_i = '0;
   logic [1:0]    ldSize_i = '0;
   logic          ldSigned_i = 1'b0;
   logic          ldReady_o, ldDataValid_o, ldMisalign_o;
   logic [DW-1:0] ldData_o;
   logic          stEn_i = 1'b0;
   logic [AW-1:0] stAddr_i = '0;
   logic [DW-1:0] stData_i = '0;
   logic [1:0]    stSize_i = '0;
   logic          stReady_o, stMisalign_o, stBufEmpty_o;
   logic [AW-1:0] memLdAddr_o;
   logic          memLdValid_o;
   logic          memLdReady_i = 1'b0;
   logic [DW-1:0] memLdData_i = '0;
   logic          memLdDataValid_i = 1'b0;
   logic [AW-1:0] memStAddr_o;
   logic [DW-1:0] memStData_o;
   logic [DW/8-1:0] memStByteEn_o;
   logic          memStValid_o;
   logic          memStReady_i = 1'b0;

   always #5 clk = ~clk;

   dcache_uncached_port #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .STB_DEPTH(DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .recoverFlag_i   (recoverFlag_i),
      .ldEn_i          (ldEn_i),
      .ldAddr_i        (ldAddr_i),
      .ldSize_i        (ldSize_i),
      .ldSigned_i      (ldSigned_i),
      .ldReady_o       (ldReady_o),
      .ldDataValid_o   (ldDataValid_o),
      .ldData_o        (ldData_o),
      .ldMisalign_o    (ldMisalign_o),
      .stEn_i          (stEn_i),
      .stAddr_i        (stAddr_i),
      .stData_i        (stData_i),
      .stSize_i        (stSize_i),
      .stReady_o       (stReady_o),
      .stMisalign_o    (stMisalign_o),
      .stBufEmpty_o    (stBufEmpty_o),
      .memLdAddr_o     (memLdAddr_o),
      .memLdValid_o    (memLdValid_o),
      .memLdReady_i    (memLdReady_i),
      .memLdData_i     (memLdData_i),
      .memLdDataValid_i(memLdDataValid_i),
      .memStAddr_o     (memStAddr_o),
      .memStData_o     (memStData_o),
      .memStByteEn_o   (memStByteEn_o),
      .memStValid_o    (memStValid_o),
      .memStReady_i    (memStReady_i)
   );

   int checks = 0;
   int errors = 0;
   int pops   = 0;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [3:0]    be;
   } st_t;

   st_t           stq[$];
   logic [DW-1:0] ldq[$];
   logic [AW-1:0] exp_ld_addr = '0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Expected load result straight from the byte-lane arithmetic.
   function automatic logic [31:0] ld_expect(input logic [31:0] word, input logic [31:0] addr,
                                             input int size, input bit sgn);
      longint v;
      longint bits;
      bits = 8 * (longint'(1) << size);
      v = longint'({32'd0, word}) >> (8 * (addr % 4));
      v = v % (longint'(1) << bits);
      if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
      return v[31:0];
   endfunction

   // Reference model and per-cycle compare, sampled mid-cycle.
   always @(negedge clk) begin
      int n;
      int nb;
      int off;
      longint d;
      st_t e;
      if (!reset) begin
         stq.delete();
         ldq.delete();
      end else begin
         n = stq.size();
         check("stReady", stReady_o, 64'(n < DEPTH));
         check("stBufEmpty", stBufEmpty_o, 64'(n == 0));
         check("memStValid", memStValid_o, 64'(n != 0));
         if (n != 0) begin
            check("memStAddr", memStAddr_o, stq[0].addr);
            check("memStData", memStData_o, stq[0].data);
            check("memStByteEn", memStByteEn_o, stq[0].be);
         end
         if (ldq.size() == 0) check("ldDataValid_spurious", ldDataValid_o, 0);
         else if (ldDataValid_o) check("ldData", ldData_o, ldq.pop_front());
         if (memLdValid_o) check("memLdAddr", memLdAddr_o, exp_ld_addr);
         if (memStValid_o && memStReady_i) pops++;

         if (n != 0 && memStReady_i) void'(stq.pop_front());
         if (stEn_i && n < DEPTH) begin
            nb  = 1 << stSize_i;
            off = int'(stAddr_i % 4);
            if (nb <= 4 && (stAddr_i % nb) == 0) begin
               d      = longint'({32'd0, stData_i}) % (longint'(1) << (8 * nb));
               e.addr = stAddr_i & ~32'd3;
               e.data = 32'(d << (8 * off));
               e.be   = 4'(((1 << nb) - 1) << off);
               stq.push_back(e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the request until accepted; returns #1 into the cycle after acceptance.
   task automatic issue_load(input logic [31:0] addr, input int size, input bit sgn);
      bit ok;
      ok = 0;
      ldEn_i = 1'b1; ldAddr_i = addr; ldSize_i = 2'(size); ldSigned_i = sgn;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ldReady_o) begin ok = 1; break; end
      end
      if (!ok) check("ld_accept_timeout", ldReady_o, 1);
      tick();
      ldEn_i = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input int size);
      bit ok;
      ok = 0;
      stEn_i = 1'b1; stAddr_i = addr; stData_i = data; stSize_i = 2'(size);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (stReady_o) begin ok = 1; break; end
      end
      if (!ok) check("st_accept_timeout", stReady_o, 1);
      tick();
      stEn_i = 1'b0;
   endtask

   // Called at T+1: ready now, data at T+2, result expected at T+3.
   task automatic serve_mem(input logic [31:0] word);
      check("memLdValid_T1", memLdValid_o, 1);
      memLdReady_i = 1'b1;
      tick();
      memLdReady_i = 1'b0; memLdDataValid_i = 1'b1; memLdData_i = word;
      tick();
      memLdDataValid_i = 1'b0;
      check("ldDataValid_T3", ldDataValid_o, 1);
   endtask

   task automatic full_load(input logic [31:0] addr, input int size, input bit sgn, input logic [31:0] word);
      exp_ld_addr = addr & ~32'd3;
      ldq.push_back(ld_expect(word, addr, size, sgn));
      issue_load(addr, size, sgn);
      serve_mem(word);
   endtask

   task automatic drain();
      memStReady_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (stBufEmpty_o) break;
      end
      check("drain_empty", stBufEmpty_o, 1);
      memStReady_i = 1'b0;
   endtask

   initial begin
      int p0;
      repeat (3) tick();
      check("rst_ldReady", ldReady_o, 0);
      check("rst_stReady", stReady_o, 0);
      check("rst_memLdValid", memLdValid_o, 0);
      check("rst_memStValid", memStValid_o, 0);
      check("rst_ldData", ldData_o, 0);
      reset = 1'b1;
      tick();

      // 1: word load, minimum latency
      full_load(32'h100, 2, 0, 32'hA1B2C3D4);
      check("t1_ldData", ldData_o, 32'hA1B2C3D4);

      // 2: signed byte and unsigned half extraction
      full_load(32'h103, 0, 1, 32'h80FF_0000);
      check("t2_lb_signed", ldData_o, 32'hFFFF_FF80);
      full_load(32'h102, 1, 0, 32'h80FF_0000);
      check("t2_lh_unsigned", ldData_o, 32'h0000_80FF);

      // 3: fill the buffer with memory stalled, then drain
      memStReady_i = 1'b0;
      for (int i = 0; i < 4; i++) do_store(32'h300 + 32'(4 * i), 32'h1111_0000 + 32'(i), 2);
      check("t3_full", stReady_o, 0);
      check("t3_memStByteEn", memStByteEn_o, 4'hF);
      p0 = pops;
      drain();
      check("t3_pops", pops - p0, 4);

      // 4: load hitting a buffered byte store
      do_store(32'h201, 32'h55, 0);
      check("t4_buffered_be", memStByteEn_o, 4'h2);
`ifdef STORE_FWD_EN
      ldq.push_back(32'h55);
      issue_load(32'h201, 0, 0);
      check("t4_fwd_valid", ldDataValid_o, 1);
      check("t4_fwd_data", ldData_o, 32'h55);
      check("t4_fwd_nomem", memLdValid_o, 0);
      drain();
`else
      ldEn_i = 1'b1; ldAddr_i = 32'h201; ldSize_i = 2'd0; ldSigned_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t4_stall_ready", ldReady_o, 0);
         check("t4_stall_nomem", memLdValid_o, 0);
      end
      tick();
      memStReady_i = 1'b1;
      exp_ld_addr = 32'h200;
      ldq.push_back(32'h55);
      issue_load(32'h201, 0, 0);
      memStReady_i = 1'b0;
      check("t4_drained", stBufEmpty_o, 1);
      serve_mem(32'h0000_5500);
      check("t4_ldData", ldData_o, 32'h55);
`endif

      // 5: flush in WAIT and in REQ; the following load must complete normally
      exp_ld_addr = 32'h400;
      issue_load(32'h400, 2, 0);
      memLdReady_i = 1'b1;
      tick();
      memLdReady_i = 1'b0; recoverFlag_i = 1'b1;
      tick();
      recoverFlag_i = 1'b0; memLdDataValid_i = 1'b1; memLdData_i = 32'hDEAD_BEEF;
      tick();
      memLdDataValid_i = 1'b0;
      check("t5_dropped", ldDataValid_o, 0);
      tick();
      check("t5_dropped2", ldDataValid_o, 0);
      issue_load(32'h400, 2, 0);
      recoverFlag_i = 1'b1;
      tick();
      recoverFlag_i = 1'b0;
      check("t5_req_withdrawn", memLdValid_o, 0);
      full_load(32'h404, 2, 0, 32'h1234_5678);
      check("t5_next_load", ldData_o, 32'h1234_5678);

      // 6: misaligned load, then reset in the middle of a request
      issue_load(32'h101, 1, 0);
      check("t6_misalign_pulse", ldMisalign_o, 1);
      check("t6_misalign_nomem", memLdValid_o, 0);
      check("t6_misalign_data", ldData_o, 0);
      tick();
      check("t6_misalign_onecycle", ldMisalign_o, 0);
      do_store(32'h600, 32'hCAFE_F00D, 2);
      exp_ld_addr = 32'h500;
      issue_load(32'h500, 2, 0);
      check("t6_req_active", memLdValid_o, 1);
      reset = 1'b0;
      #1;
      check("t6_rst_memLdValid", memLdValid_o, 0);
      check("t6_rst_ldReady", ldReady_o, 0);
      check("t6_rst_stReady", stReady_o, 0);
      check("t6_rst_memStValid", memStValid_o, 0);
      check("t6_rst_ldDataValid", ldDataValid_o, 0);
      check("t6_rst_memStByteEn", memStByteEn_o, 0);
      tick();
      reset = 1'b1;
      tick();

      do_store(32'h301, 32'hBEEF, 1);
      check("t6_st_misalign", stMisalign_o, 1);
      check("t6_st_dropped", stBufEmpty_o, 1);
      full_load(32'h102, 0, 0, 32'h80FF_0000);
      check("t6_after_reset", ldData_o, 32'h0000_00FF);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule
